// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a bank of common-anode 7-segment digits that share one
// hex-to-segment decoder.
// - A packed hex word is captured once per frame, so the display never tears.
// - Each digit slot starts with a short blank interval to prevent ghosting.
// - All outputs are decoded only from registered state.
module seg7_scan_ctrl #(
   parameter int N_DIGITS     = 8,
   parameter int SLOT_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 2000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] data,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic                  lz_blank,
   output logic [3:0]            hex,
   output logic [N_DIGITS-1:0]   an,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

   typedef enum logic {PH_BLANK, PH_ON} phase_t;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*N_DIGITS-1:0] data_sh_q, data_sh_d;
   logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [N_DIGITS-1:0]   en_sh_q, en_sh_d;
   logic                  lz_sh_q, lz_sh_d;

   phase_t                phase;
   logic [3:0]            nib [N_DIGITS];
   logic [N_DIGITS-1:0]   sel;
   logic [N_DIGITS-1:0]   visible;
   logic [N_DIGITS-1:0]   zero_blank;
   logic [N_DIGITS:1]     zero_from;   // nibbles gi..N_DIGITS-1 of the shadow are all zero
   logic                  dp_lit;

   // Next state: the slot counter wraps explicitly, and the digit index advances on each wrap.
   // The shadow registers load only in the first cycle of a frame.
   always_comb begin
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      data_sh_d = data_sh_q;
      dp_sh_d   = dp_sh_q;
      en_sh_d   = en_sh_q;
      lz_sh_d   = lz_sh_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      if (idx_q == '0 && cnt_q == '0) begin
         data_sh_d = data;
         dp_sh_d   = dp_in;
         en_sh_d   = digit_en;
         lz_sh_d   = lz_blank;
      end
   end

   // State registers; reset takes effect at the next edge and drops any partial slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         data_sh_q <= '0;
         dp_sh_q   <= '0;
         en_sh_q   <= '0;
         lz_sh_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         data_sh_q <= data_sh_d;
         dp_sh_q   <= dp_sh_d;
         en_sh_q   <= en_sh_d;
         lz_sh_q   <= lz_sh_d;
      end
   end

   assign phase      = (cnt_q < CNT_BLANK) ? PH_BLANK : PH_ON;
   assign frame_done = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

   assign zero_from[N_DIGITS] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         assign nib[gi] = data_sh_q[4*gi +: 4];
         assign sel[gi] = (idx_q == IW'(gi));
         if (gi == 0) begin : g_lsd
            // The least significant digit always shows, even when it is zero.
            assign zero_blank[gi] = 1'b0;
         end else begin : g_upper
            assign zero_from[gi]  = (nib[gi] == 4'h0) && zero_from[gi+1];
            assign zero_blank[gi] = lz_sh_q && zero_from[gi];
         end
         assign visible[gi] = en_sh_q[gi] && !zero_blank[gi];
         assign an[gi]      = ~((phase == PH_ON) && sel[gi] && visible[gi]);
      end
   endgenerate

   // The current digit's nibble goes to the decoder in both phases, so the decoder settles before the anode turns on.
   always_comb begin
      hex    = 4'h0;
      dp_lit = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (sel[i]) begin
            hex    = hex | nib[i];
            dp_lit = dp_lit | (visible[i] & dp_sh_q[i]);
         end
      end
   end

   assign dp = ~((phase == PH_ON) && dp_lit);

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with N_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
// The stimulus process expands hand-written per-slot tables into per-cycle
// expectations. A separate monitor pops one expectation on each falling edge
// and compares it with the DUT outputs.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        lz_blank;
   logic [3:0]  hex;
   logic [3:0]  an;
   logic        dp;
   logic        frame_done;

   typedef struct {
      logic [3:0] an;
      logic       dp;
      logic [3:0] hex;
      logic       fd;
      int         frame;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic [3:0] last_hex0 = 4'h0;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .N_DIGITS    (4),
      .SLOT_CYCLES (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .data      (data),
      .dp_in     (dp_in),
      .digit_en  (digit_en),
      .lz_blank  (lz_blank),
      .hex       (hex),
      .an        (an),
      .dp        (dp),
      .frame_done(frame_done)
   );

   // Monitor: compare the outputs once per cycle, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (an !== e.an || dp !== e.dp || hex !== e.hex || frame_done !== e.fd) begin
            errors++;
            $display("FAIL frame%0d cyc%0d: got an=%b dp=%b hex=%h fd=%b, expected an=%b dp=%b hex=%h fd=%b",
                     e.frame, e.cyc, an, dp, hex, frame_done, e.an, e.dp, e.hex, e.fd);
         end else begin
            $display("frame%0d cyc%0d: an=%b dp=%b hex=%h fd=%b ok", e.frame, e.cyc, an, dp, hex, frame_done);
         end
      end
   end

   task automatic push_exp(input logic [3:0] a, input logic d, input logic [3:0] h,
                           input logic f, input int fr, input int c);
      exp_t e;
      e.an = a; e.dp = d; e.hex = h; e.fd = f; e.frame = fr; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // Run one frame, starting in its first cycle, just after an active edge.
   // eh  : the hand-written nibble shown in each slot
   // lit : the slots whose anode lights
   // dpl : the slots whose decimal point lights
   // The cycle-0 nibble is the previous frame's digit 0, because the snapshot lands at the end of that cycle.
   task automatic run_frame(input int fr, input logic [15:0] d, input logic [3:0] dpi,
                            input logic [3:0] en, input logic lz,
                            input logic [15:0] eh, input logic [3:0] lit, input logic [3:0] dpl,
                            input int chg_at, input logic [15:0] chg_d, input int rst_at);
      data = d; dp_in = dpi; digit_en = en; lz_blank = lz;
      for (int c = 0; c < 32; c++) begin
         int s, k;
         logic [3:0] ea, eh_n;
         logic ed;
         s = c / 8;
         k = c % 8;
         eh_n = (c == 0) ? last_hex0 : eh[4*s +: 4];
         ea = (k < 2 || !lit[s]) ? 4'b1111 : ~(4'b0001 << s);
         ed = !(k >= 2 && lit[s] && dpl[s]);
         push_exp(ea, ed, eh_n, (c == 31), fr, c);
         if (c == chg_at) data = chg_d;
         if (c == rst_at) reset = 1'b1;
         @(posedge clk); #1;
         if (c == rst_at) begin
            reset = 1'b0;
            last_hex0 = 4'h0;
            return;
         end
      end
      last_hex0 = eh[3:0];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; data = 16'hFFFF; dp_in = 4'hF; digit_en = 4'hF; lz_blank = 1'b0;
      // Reset state: all anodes off, dp off, hex 0, no frame pulse.
      repeat (2) begin
         @(posedge clk); #1;
         push_exp(4'b1111, 1'b1, 4'h0, 1'b0, -1, 0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      // Basic scan; data changing mid-frame must not tear the frame.
      run_frame(0, 16'h1234, 4'b0000, 4'b1111, 1'b0, 16'h1234, 4'b1111, 4'b0000, 10, 16'hABCD, -1);
      run_frame(1, 16'hABCD, 4'b0000, 4'b1111, 1'b0, 16'hABCD, 4'b1111, 4'b0000, -1, 16'h0, -1);
      // Leading-zero suppression; the dp of a blanked digit stays dark.
      run_frame(2, 16'h0050, 4'b1111, 4'b1111, 1'b1, 16'h0050, 4'b0011, 4'b0011, -1, 16'h0, -1);
      // An interior zero is not leading, so only digit 3 blanks.
      run_frame(3, 16'h0300, 4'b1000, 4'b1111, 1'b1, 16'h0300, 4'b0111, 4'b0000, -1, 16'h0, -1);
      // Disabled digits still use their slots.
      run_frame(4, 16'h1234, 4'b0111, 4'b0101, 1'b0, 16'h1234, 4'b0101, 4'b0101, -1, 16'h0, -1);
      // An all-zero word leaves only digit 0 lit.
      run_frame(5, 16'h0000, 4'b0001, 4'b1111, 1'b1, 16'h0000, 4'b0001, 4'b0001, -1, 16'h0, -1);
      // Reset asserted in cycle 20 (digit 2, ON phase), then the scan restarts.
      run_frame(6, 16'h5A3C, 4'b0000, 4'b1111, 1'b0, 16'h5A3C, 4'b1111, 4'b0000, -1, 16'h0, 20);
      run_frame(7, 16'h9876, 4'b0010, 4'b1111, 1'b0, 16'h9876, 4'b1111, 4'b0010, -1, 16'h0, -1);

      for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
      @(posedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one hex-to-segment decoder. It snapshots a packed hex word once per frame and steps through the digits at a fixed slot rate. For each digit it drives the 4-bit value into the shared decoder and asserts that digit's anode. Each slot opens with an anti-ghosting blank interval. The block sits between the display-data registers and the decoder/pin outputs.

## Interface
Parameters:
- N_DIGITS, 8, number of digits scanned (2..16)
- SLOT_CYCLES, 100000, clock cycles per digit slot (>= BLANK_CYCLES+1)
- BLANK_CYCLES, 2000, cycles at slot start with all anodes off (>= 1)

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on clk rising edge
- data  in  4*N_DIGITS  hex value per digit; digit i = data[4i+3:4i], digit 0 least significant
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
- digit_en  in  N_DIGITS  1 = digit participates; 0 = digit stays dark in its slot
- lz_blank  in  1  1 = suppress leading zeros
- hex  out  4  nibble to shared hex-to-segment decoder
- an  out  N_DIGITS  anode enables, active-low
- dp  out  1  decimal point segment, active-low
- frame_done  out  1  one-cycle pulse in the last cycle of each frame

## Operation
- State: slot counter cnt (0..SLOT_CYCLES-1), digit index idx (0..N_DIGITS-1), shadow registers data_sh, dp_sh, en_sh, lz_sh.
- cnt increments every cycle. At SLOT_CYCLES-1 it wraps to 0 and idx increments. idx wraps from N_DIGITS-1 to 0. A frame is N_DIGITS*SLOT_CYCLES cycles.
- Phase BLANK applies when cnt < BLANK_CYCLES. Phase ON applies otherwise. No other states.
- Snapshot: in the cycle with idx==0 and cnt==0, the shadow registers load from data/dp_in/digit_en/lz_blank at that cycle's end. Input changes at any other time have no visible effect until the next frame. The display never tears mid-frame.
- Leading-zero mask, computed from the shadow: digit i is blanked if lz_sh=1, i != 0, and data_sh nibbles i..N_DIGITS-1 are all zero. Digit 0 is never zero-blanked. The dp of a blanked digit is also dark.
- Visible(idx) = en_sh[idx] and not zero-blanked.
- ON phase: an[idx]=0 if visible(idx), all other an bits 1. dp = ~dp_sh[idx] if visible, else 1.
- BLANK phase: an all 1s, dp=1.
- hex = data_sh nibble idx during both phases, so the decoder settles before the anode turns on.
- A disabled or blanked digit still consumes its full slot, which keeps the duty cycle uniform.
- frame_done=1 exactly when idx==N_DIGITS-1 and cnt==SLOT_CYCLES-1, otherwise 0.

## Timing
- All outputs are registered, or decoded purely from registered state. There is no combinational path from data/dp_in/digit_en/lz_blank to any output.
- Reset values: cnt=0, idx=0, all shadows 0, an all 1s, dp=1, hex=0, frame_done=0.
- First cycle after reset deasserts: idx=0, cnt=0. The snapshot is taken in that cycle. The first anode asserts BLANK_CYCLES cycles later.
- Reset asserted mid-frame: at the next edge all state returns to reset values and an goes all 1s. No partial slot completes.
- Anode transition: anode k deasserts at the slot boundary, and BLANK_CYCLES cycles later anode k+1 asserts. Two anodes are never low together.
- Counter widths: cnt is $clog2(SLOT_CYCLES) bits; idx is max(1,$clog2(N_DIGITS)) bits. Wrap is explicit compare, not overflow, so non-power-of-two values are exact.

## Test plan
Bench parameters: N_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
- Reset, data=16'h1234, all enabled, lz_blank=0 -> for 2 cycles an=4'b1111. Then for 6 cycles an=4'b1110 with hex=4. Then the next slot gives 2 blank cycles, then an=4'b1101 with hex=3, and so on. frame_done pulses at cycle 31 and every 32 cycles after.
- data changes from 16'h1234 to 16'hABCD at cycle 10 -> the rest of frame 0 shows 3,2,1. Frame 1 (from cycle 32) shows D,C,B,A.
- data=16'h0050, lz_blank=1 -> digits 3 and 2 stay dark (an bits 1) for their full slots. Digit 1 shows hex=5. Digit 0 shows hex=0 and is lit.
- digit_en=4'b0101, dp_in=4'b0111 -> anodes 1 and 3 are never low. dp=0 only during the ON phase of digit 0 and digit 2. The frame length is still 32 cycles.
- data=16'h0000, lz_blank=1 -> only digit 0 lights, with hex=0.
- Reset asserted at cycle 20 (idx=2, ON phase) for 1 cycle -> the next cycle has an=4'b1111, hex=0, frame_done=0. Scanning restarts at idx=0 and the first anode goes low 2 cycles after reset drops.
